regwrite_arbiter: RTL and testbench
===================================

Name: regwrite_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - the WB stage, which has fixed priority and is never stalled;
  - a multi-cycle unit (MDU), buffered in a DEPTH-entry FIFO with a valid/ready handshake.
- Keeps a 32-bit pending scoreboard of destinations issued to the MDU but not yet written, so the ID-stage hazard logic can stall.
- Sits between the WB/MDU outputs and the register file's RegWrite/WriteReg/WriteData inputs.

Parameters:
DEPTH, 2, MDU result FIFO entries (legal 1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
wb_we  in  1  WB-stage write request
wb_reg  in  5  WB destination register
wb_data  in  32  WB write data
mdu_valid  in  1  MDU result valid
mdu_reg  in  5  MDU destination register
mdu_data  in  32  MDU result data
mdu_ready  out  1  FIFO can accept this cycle
issue_valid  in  1  ID issues an instruction to the MDU this cycle
issue_reg  in  5  destination of the issued MDU instruction
RegWrite  out  1  register file write enable
WriteReg  out  5  register file write address
WriteData  out  32  register file write data
grant_src  out  1  0 = WB owns the port, 1 = FIFO head owns it
pending  out  32  bit r = 1: register r has an outstanding MDU write
hazard_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, pointers 0, count 0, pending=0, hazard_err=0. While rst_n=0, every output is forced 0, including mdu_ready. Reset mid-operation discards buffered MDU results without writing them.
- mdu_ready = (count < DEPTH). It depends only on registered count; a pop in the same cycle does not raise ready.
- Push: on a rising edge with mdu_valid && mdu_ready, {mdu_reg, mdu_data} is written at the write pointer. There is no bypass: an accepted result reaches the port no earlier than the next cycle.
- Port grant is combinational each cycle:
  - wb_we=1 and wb_reg≠0: RegWrite=1, WriteReg=wb_reg, WriteData=wb_data, grant_src=0. The FIFO does not pop.
  - Else if FIFO non-empty: head drives WriteReg/WriteData, grant_src=1, and the head pops at the clock edge.
    - RegWrite=1 only if head reg≠0.
    - A head with reg 0 still pops, consuming the slot with no write.
  - Else: RegWrite=0, WriteReg=0, WriteData=0, grant_src=0.
- wb_we=1 with wb_reg=0: treated as no WB request; the FIFO may drain that cycle.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged. When full, ready=0 even if popping.
- Scoreboard:
  - issue_valid && issue_reg≠0 sets pending[issue_reg].
  - A FIFO pop with reg r≠0 clears pending[r].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is always 0.
- hazard_err is set (sticky until reset) on any of:
  - an issue to a register already pending with no same-cycle clear;
  - a WB write (wb_we, wb_reg≠0) to a pending register (WAW);
  - mdu_valid to a register whose pending bit is 0.
- Invalid requests are not blocked: they are still performed.
- Latency:
  - WB to register file: 0 cycles (combinational).
  - MDU accept to write: ≥1 cycle, plus one cycle per WB-occupied cycle ahead of it.
- Starvation of the FIFO under continuous WB writes is accepted. The pending bits keep ID stalled, so results are preserved, not lost.

Test Plan:
- Reset, then no traffic: RegWrite=0, mdu_ready=1, pending=0, hazard_err=0. Assert rst_n=0 mid-run: all outputs 0 immediately, without waiting for a clock edge.
- Issue r8, MDU writes r8=0x0000_00A5 with WB idle: pending[8]=1 after issue. The following cycle gives RegWrite=1, WriteReg=8, WriteData=0xA5, grant_src=1. pending[8]=0 after that edge.
- WB writes r3=0x1234 for 3 cycles while MDU pushes r9=0xBEEF (r9 issued earlier): WB owns the port for 3 cycles. r9 is written on the 4th cycle; the FIFO stays non-empty throughout.
- DEPTH=2 with WB busy, MDU pushes r10, r11, then offers r12: mdu_ready=0 after 2 pushes and r12 is held. Drain order is r10, r11, r12, with no loss or reordering.
- MDU result to r0, and wb_we with wb_reg=0: RegWrite stays 0, the FIFO entry pops, no pending change.
- Violations:
  - issue r5 twice without a write: hazard_err=1.
  - after reset, WB writes r6 while r6 is pending: hazard_err=1, and the write is still performed.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Arbitrates the register-file write port between the WB stage (fixed priority)
// and a small FIFO of MDU results, and tracks outstanding MDU destinations.
module regwrite_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        grant_src,
  output logic [31:0] pending,
  output logic        hazard_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending_q, pending_nxt, set_vec, clr_vec;
  logic          hazard_q, hazard_nxt;
  logic          wb_act, nonempty, ready_int, push, pop;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign wb_act    = wb_we && (wb_reg != 5'd0);
  assign nonempty  = (count != '0);
  assign ready_int = (count < CW'(DEPTH));
  assign push      = mdu_valid && ready_int;
  assign pop       = !wb_act && nonempty;
  assign head_reg  = fifo_reg[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= mdu_reg;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_reg != 5'd0)) set_vec[issue_reg] = 1'b1;
    if (pop && (head_reg != 5'd0))          clr_vec[head_reg]  = 1'b1;
    pending_nxt    = (pending_q & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
    hazard_nxt = hazard_q
               | (issue_valid && (issue_reg != 5'd0) && pending_q[issue_reg] && !clr_vec[issue_reg])
               | (wb_act && pending_q[wb_reg])
               | (mdu_valid && !pending_q[mdu_reg]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      hazard_q  <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      hazard_q  <= hazard_nxt;
    end
  end

  // Outputs are gated by rst_n so they drop immediately on reset assertion.
  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = 5'd0;
    WriteData = 32'd0;
    grant_src = 1'b0;
    if (rst_n) begin
      if (wb_act) begin
        RegWrite  = 1'b1;
        WriteReg  = wb_reg;
        WriteData = wb_data;
      end else if (nonempty) begin
        RegWrite  = (head_reg != 5'd0);
        WriteReg  = head_reg;
        WriteData = head_data;
        grant_src = 1'b1;
      end
    end
  end

  assign mdu_ready  = rst_n && ready_int;
  assign pending    = rst_n ? pending_q : 32'd0;
  assign hazard_err = rst_n && hazard_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: expected port writes are queued at
// stimulus time and a negedge monitor pops and compares each observed write.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, mdu_valid, issue_valid;
  logic [4:0]  wb_reg, mdu_reg, issue_reg;
  logic [31:0] wb_data, mdu_data;
  logic        mdu_ready, RegWrite, grant_src, hazard_err;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        src;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  regwrite_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .grant_src(grant_src), .pending(pending), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write the port presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RegWrite === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got src=%0d reg=%0d data=%h, expected none",
                 grant_src, WriteReg, WriteData);
      end else begin
        e = exp_q.pop_front();
        if (grant_src !== e.src || WriteReg !== e.r || WriteData !== e.d) begin
          errors++;
          $display("FAIL port_write: got src=%0d reg=%0d data=%h, expected src=%0d reg=%0d data=%h",
                   grant_src, WriteReg, WriteData, e.src, e.r, e.d);
        end
      end
    end
  end

  task automatic idle();
    wb_we = 0; wb_reg = 0; wb_data = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
    issue_valid = 0; issue_reg = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic src, input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{src: src, r: r, d: d});
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();

    // Reset, no traffic
    step();
    chk("idle_regwrite", RegWrite, 0);
    chk("idle_ready", mdu_ready, 1);
    chk("idle_pending", pending, 0);
    chk("idle_hazard", hazard_err, 0);

    // Issue r8, MDU returns 0xA5 with WB idle
    issue_valid = 1; issue_reg = 8;
    step();
    idle();
    chk("r8_pending_set", pending, 32'h0000_0100);
    mdu_valid = 1; mdu_reg = 8; mdu_data = 32'hA5;
    expect_wr(1, 8, 32'hA5);
    step();
    idle();
    chk("r8_grant_src", grant_src, 1);
    step();
    chk("r8_pending_clr", pending, 0);
    chk("r8_hazard", hazard_err, 0);

    // WB owns the port 3 cycles while r9 waits in the FIFO
    issue_valid = 1; issue_reg = 9;
    step();
    idle();
    wb_we = 1; wb_reg = 3; wb_data = 32'h1234;
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'hBEEF;
    expect_wr(0, 3, 32'h1234);
    step();
    mdu_valid = 0;
    expect_wr(0, 3, 32'h1234);
    step();
    chk("r9_still_pending", pending, 32'h0000_0200);
    expect_wr(0, 3, 32'h1234);
    step();
    idle();
    expect_wr(1, 9, 32'hBEEF);
    step();
    chk("r9_pending_clr", pending, 0);

    // FIFO full with WB busy; r12 held until space frees
    for (int i = 10; i <= 12; i++) begin
      issue_valid = 1; issue_reg = 5'(i);
      step();
    end
    idle();
    chk("fill_pending", pending, 32'h0000_1C00);
    wb_we = 1; wb_reg = 1; wb_data = 32'h11;
    mdu_valid = 1; mdu_reg = 10; mdu_data = 32'hA0A0;
    expect_wr(0, 1, 32'h11);
    step();
    mdu_reg = 11; mdu_data = 32'hB1B1;
    chk("fill_ready_1", mdu_ready, 1);
    expect_wr(0, 1, 32'h11);
    step();
    mdu_reg = 12; mdu_data = 32'hC2C2;
    chk("full_ready_0", mdu_ready, 0);
    expect_wr(0, 1, 32'h11);
    step();
    wb_we = 0;
    chk("full_pop_ready_0", mdu_ready, 0);
    expect_wr(1, 10, 32'hA0A0);
    step();
    chk("after_pop_ready_1", mdu_ready, 1);
    expect_wr(1, 11, 32'hB1B1);
    step();
    mdu_valid = 0;
    expect_wr(1, 12, 32'hC2C2);
    step();
    chk("drain_pending", pending, 0);
    chk("drain_hazard", hazard_err, 0);

    // r0 result and wb_we with reg 0: slot consumed, no write
    mdu_valid = 1; mdu_reg = 0; mdu_data = 32'h55;
    wb_we = 1; wb_reg = 0; wb_data = 32'h77;
    step();
    mdu_valid = 0;
    chk("r0_grant_src", grant_src, 1);
    chk("r0_regwrite", RegWrite, 0);
    chk("r0_writedata", WriteData, 32'h55);
    step();
    idle();
    chk("r0_popped", grant_src, 0);
    chk("r0_pending", pending, 0);
    chk("r0_hazard", hazard_err, 1);

    // Mid-run reset with a buffered result: outputs drop immediately, entry discarded
    do_reset();
    issue_valid = 1; issue_reg = 20;
    step();
    idle();
    wb_we = 1; wb_reg = 4; wb_data = 32'h44;
    mdu_valid = 1; mdu_reg = 20; mdu_data = 32'hDEAD;
    expect_wr(0, 4, 32'h44);
    step();
    mdu_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_grant", grant_src, 0);
    chk("rst_ready", mdu_ready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_hazard", hazard_err, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    step();
    step();
    chk("post_rst_ready", mdu_ready, 1);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_grant", grant_src, 0);

    // Double issue to r5
    issue_valid = 1; issue_reg = 5;
    step();
    chk("r5_no_hazard_yet", hazard_err, 0);
    step();
    idle();
    chk("r5_double_issue", hazard_err, 1);

    // WAW: WB write to pending r6 is flagged but still performed
    do_reset();
    issue_valid = 1; issue_reg = 6;
    step();
    idle();
    chk("r6_hazard_before", hazard_err, 0);
    wb_we = 1; wb_reg = 6; wb_data = 32'h66;
    expect_wr(0, 6, 32'h66);
    step();
    idle();
    chk("r6_waw_hazard", hazard_err, 1);
    chk("r6_still_pending", pending, 32'h0000_0040);

    step();
    step();
    chk("expected_writes_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
